// File: rtl/oram_access_arbiter.sv
// Round-robin arbiter sharing one oram_module port among NREQ requesters, one access in flight; ORAM_TIMEOUT_EN adds a WAIT watchdog.
// Latency: req_ready at T, oram_input_ready at T+1, rsp_valid one cycle after oram_output_ready is seen.
// Backpressure: requesters hold req_valid until req_ready; responses are single-cycle pulses with no stall.
module oram_access_arbiter #(
    parameter int NREQ    = 4,
    parameter int D       = 6,
    parameter int A       = 8,
    parameter int TIMEOUT = 1024
) (
    input  logic                  i_clk,
    input  logic                  i_rst,
    input  logic [NREQ-1:0]       i_req_valid,
    input  logic [NREQ-1:0]       i_req_rw,
    input  logic [NREQ*D-1:0]     i_req_block,
    input  logic [NREQ*8*A-1:0]   i_req_wdata,
    output logic [NREQ-1:0]       o_req_ready,
    output logic [NREQ-1:0]       o_rsp_valid,
    output logic [8*A-1:0]        o_rsp_rdata,
    output logic                  o_rsp_err,
    output logic [D-1:0]          o_oram_block,
    output logic [8*A-1:0]        o_oram_wvalue,
    output logic                  o_oram_rw,
    output logic                  o_oram_input_ready,
    input  logic [8*A-1:0]        i_oram_r_value,
    input  logic                  i_oram_output_ready
);

    localparam int GW = $clog2(NREQ);
    localparam int W  = 8 * A;

    typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_WAIT, S_RESP} state_t;

    typedef struct packed {
        logic          rw;
        logic [D-1:0]  blk;
        logic [W-1:0]  wdat;
    } req_t;

    state_t          r_state;
    logic [GW-1:0]   r_last_grant;
    logic [GW-1:0]   r_grant;
    req_t            r_req;

    logic            w_gnt_vld;
    logic [GW-1:0]   w_gnt_idx;
    logic [NREQ-1:0] w_gnt_onehot;
    logic [NREQ-1:0] w_rsp_onehot;

`ifdef ORAM_TIMEOUT_EN
    localparam logic [15:0] TO_LAST = 16'(TIMEOUT - 1);
    logic [15:0]     r_timer;
`endif

    // Scan from the highest offset down so the nearest requester after last_grant wins.
    always_comb begin
        w_gnt_vld = 1'b0;
        w_gnt_idx = '0;
        for (int i = NREQ; i >= 1; i--) begin
            if (i_req_valid[(int'(r_last_grant) + i) % NREQ]) begin
                w_gnt_vld = 1'b1;
                w_gnt_idx = GW'((int'(r_last_grant) + i) % NREQ);
            end
        end
    end

    assign w_gnt_onehot = {{(NREQ-1){1'b0}}, 1'b1} << w_gnt_idx;
    assign w_rsp_onehot = {{(NREQ-1){1'b0}}, 1'b1} << r_grant;

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_state            <= S_IDLE;
            r_last_grant       <= GW'(NREQ - 1);
            r_grant            <= '0;
            r_req              <= '0;
            o_req_ready        <= '0;
            o_rsp_valid        <= '0;
            o_rsp_rdata        <= '0;
            o_rsp_err          <= 1'b0;
            o_oram_block       <= '0;
            o_oram_wvalue      <= '0;
            o_oram_rw          <= 1'b0;
            o_oram_input_ready <= 1'b0;
`ifdef ORAM_TIMEOUT_EN
            r_timer            <= '0;
`endif
        end else begin
            o_req_ready        <= '0;
            o_rsp_valid        <= '0;
            o_oram_input_ready <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (w_gnt_vld) begin
                        r_grant     <= w_gnt_idx;
                        r_req.rw    <= i_req_rw[w_gnt_idx];
                        r_req.blk   <= i_req_block[w_gnt_idx*D +: D];
                        r_req.wdat  <= i_req_wdata[w_gnt_idx*W +: W];
                        o_req_ready <= w_gnt_onehot;
                        r_state     <= S_ISSUE;
                    end
                end
                S_ISSUE: begin
                    o_oram_input_ready <= 1'b1;
                    o_oram_block       <= r_req.blk;
                    o_oram_wvalue      <= r_req.wdat;
                    o_oram_rw          <= r_req.rw;
`ifdef ORAM_TIMEOUT_EN
                    r_timer            <= '0;
`endif
                    r_state            <= S_WAIT;
                end
                S_WAIT: begin
                    // A response arriving on the timeout cycle still counts as a normal completion.
                    if (i_oram_output_ready) begin
                        o_rsp_valid <= w_rsp_onehot;
                        o_rsp_rdata <= r_req.rw ? '0 : i_oram_r_value;
                        o_rsp_err   <= 1'b0;
                        r_state     <= S_RESP;
                    end
`ifdef ORAM_TIMEOUT_EN
                    else if (r_timer == TO_LAST) begin
                        o_rsp_valid <= w_rsp_onehot;
                        o_rsp_rdata <= '0;
                        o_rsp_err   <= 1'b1;
                        r_state     <= S_RESP;
                    end else begin
                        r_timer <= r_timer + 16'd1;
                    end
`endif
                end
                S_RESP: begin
                    r_last_grant <= r_grant;
                    r_state      <= S_IDLE;
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_oram_access_arbiter.sv
// Directed + randomized bench for oram_access_arbiter; an ORAM memory model and a
// rotate-and-pick grant model supply every expected value.
`timescale 1ns/1ps
module tb_oram_access_arbiter;

    localparam int NREQ    = 4;
    localparam int D       = 6;
    localparam int A       = 8;
    localparam int W       = 8 * A;
    localparam int TIMEOUT = 16;

    logic                clk = 1'b0;
    logic                rst = 1'b1;
    logic [NREQ-1:0]     rq_valid = '0;
    logic [NREQ-1:0]     rq_rw = '0;
    logic [NREQ*D-1:0]   rq_block = '0;
    logic [NREQ*W-1:0]   rq_wdata = '0;
    logic [NREQ-1:0]     o_req_ready;
    logic [NREQ-1:0]     o_rsp_valid;
    logic [W-1:0]        o_rsp_rdata;
    logic                o_rsp_err;
    logic [D-1:0]        o_oram_block;
    logic [W-1:0]        o_oram_wvalue;
    logic                o_oram_rw;
    logic                o_oram_input_ready;
    logic [W-1:0]        orm_val = '0;
    logic                orm_rdy = 1'b0;

    int n_vec = 0;
    int n_err = 0;
    int last_g;
    logic [W-1:0] mem [64];

    oram_access_arbiter #(.NREQ(NREQ), .D(D), .A(A), .TIMEOUT(TIMEOUT)) dut (
        .i_clk              (clk),
        .i_rst              (rst),
        .i_req_valid        (rq_valid),
        .i_req_rw           (rq_rw),
        .i_req_block        (rq_block),
        .i_req_wdata        (rq_wdata),
        .o_req_ready        (o_req_ready),
        .o_rsp_valid        (o_rsp_valid),
        .o_rsp_rdata        (o_rsp_rdata),
        .o_rsp_err          (o_rsp_err),
        .o_oram_block       (o_oram_block),
        .o_oram_wvalue      (o_oram_wvalue),
        .o_oram_rw          (o_oram_rw),
        .o_oram_input_ready (o_oram_input_ready),
        .i_oram_r_value     (orm_val),
        .i_oram_output_ready(orm_rdy)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [NREQ-1:0] onehot(input int g);
        logic [NREQ-1:0] one;
        one = 1;
        return (g < 0) ? '0 : (one << g);
    endfunction

    // Rotate the request mask so the requester after last sits at bit 0, then take the lowest set bit.
    function automatic int model_grant(input logic [NREQ-1:0] mask, input int last);
        logic [2*NREQ-1:0] dbl;
        dbl = {mask, mask} >> ((last + 1) % NREQ);
        for (int k = 0; k < NREQ; k++)
            if (dbl[k]) return (last + 1 + k) % NREQ;
        return -1;
    endfunction

    task automatic set_req(input int i, input logic rw, input int blk, input logic [W-1:0] wd);
        rq_rw[i]              = rw;
        rq_block[i*D +: D]    = D'(blk);
        rq_wdata[i*W +: W]    = wd;
        rq_valid[i]           = 1'b1;
    endtask

    function automatic logic [W-1:0] rnd64();
        return {$urandom, $urandom};
    endfunction

    // One full access: grant, issue, ORAM reply after 'delay' WAIT cycles, response, idle.
    task automatic access(input int delay, input bit hold);
        int g;
        int n;
        logic ex_rw;
        logic [D-1:0] ex_blk;
        logic [W-1:0] ex_wd;
        logic [W-1:0] ex_rd;
        g = model_grant(rq_valid, last_g);
        for (n = 0; n < 20 && o_req_ready == '0; n++) @(negedge clk);
        chk("req_ready", o_req_ready, onehot(g));
        if (g < 0 || o_req_ready == '0) return;
        ex_rw  = rq_rw[g];
        ex_blk = rq_block[g*D +: D];
        ex_wd  = rq_wdata[g*W +: W];
        if (hold) set_req(g, 1'($urandom_range(0, 1)), $urandom_range(0, 7), rnd64());
        else rq_valid[g] = 1'b0;
        @(negedge clk);
        chk("input_ready", o_oram_input_ready, 1);
        chk("req_ready_pulse", o_req_ready, 0);
        chk("oram_rw", o_oram_rw, ex_rw);
        chk("oram_block", o_oram_block, ex_blk);
        chk("oram_wvalue", o_oram_wvalue, ex_wd);
        for (n = 1; n < delay; n++) begin
            @(negedge clk);
            chk("wait_quiet", {o_oram_input_ready, o_rsp_valid, o_req_ready}, 0);
        end
        ex_rd   = ex_rw ? '0 : mem[ex_blk];
        orm_rdy = 1'b1;
        orm_val = mem[o_oram_block];
        @(negedge clk);
        orm_rdy = 1'b0;
        orm_val = rnd64();
        chk("rsp_valid", o_rsp_valid, onehot(g));
        chk("rsp_rdata", o_rsp_rdata, ex_rd);
        chk("rsp_err", o_rsp_err, 0);
        if (ex_rw) mem[ex_blk] = ex_wd;
        last_g = g;
        @(negedge clk);
        chk("rsp_pulse", o_rsp_valid, 0);
        chk("rdata_hold", o_rsp_rdata, ex_rd);
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "watchdog");
    end

    initial begin
        int n;
        int cnt;
        logic [NREQ-1:0] m;
        for (int i = 0; i < 64; i++) mem[i] = rnd64();
        last_g = NREQ - 1;

        // Reset state
        repeat (3) @(negedge clk);
        chk("rst_req_ready", o_req_ready, 0);
        chk("rst_rsp_valid", o_rsp_valid, 0);
        chk("rst_rsp_rdata", o_rsp_rdata, 0);
        chk("rst_rsp_err", o_rsp_err, 0);
        chk("rst_oram_pins", {o_oram_block, o_oram_rw, o_oram_input_ready}, 0);
        chk("rst_oram_wvalue", o_oram_wvalue, 0);
        rst = 1'b0;
        @(negedge clk);

        // Write then read-after-write from a different requester
        set_req(1, 1'b1, 5, 64'hDEADBEEFCAFEF00D);
        access(3, 0);
        set_req(2, 1'b0, 5, rnd64());
        access(2, 0);
        chk("raw_literal", o_rsp_rdata, 64'hDEADBEEFCAFEF00D);

        // Fairness from a fresh reset: all requesters held for 8 accesses
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        last_g = NREQ - 1;
        for (int i = 0; i < NREQ; i++) set_req(i, 1'($urandom_range(0, 1)), $urandom_range(0, 7), rnd64());
        for (int k = 0; k < 8; k++) access($urandom_range(1, 4), 1);
        rq_valid = '0;
        @(negedge clk);

        // Stray output_ready while idle
        orm_rdy = 1'b1;
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            chk("stray_idle", {o_rsp_valid, o_req_ready, o_oram_input_ready}, 0);
        end
        orm_rdy = 1'b0;
        set_req(3, 1'b0, 5, rnd64());
        access(2, 0);

        // Randomized traffic with drops and varied ORAM latency
        for (int it = 0; it < 40; it++) begin
            m = NREQ'($urandom_range(0, (1 << NREQ) - 1));
            for (int i = 0; i < NREQ; i++)
                if (m[i] && !rq_valid[i]) set_req(i, 1'($urandom_range(0, 1)), $urandom_range(0, 7), rnd64());
            if ($urandom_range(0, 4) == 0) rq_valid[$urandom_range(0, NREQ - 1)] = 1'b0;
            if (rq_valid == '0) set_req(it % NREQ, 1'b0, $urandom_range(0, 7), rnd64());
            access($urandom_range(1, 6), 0);
        end
        rq_valid = '0;
        @(negedge clk);

        // Reset asserted mid-access aborts it
        set_req(1, 1'b0, 9, rnd64());
        for (n = 0; n < 20 && o_req_ready == '0; n++) @(negedge clk);
        chk("abort_grant", o_req_ready, onehot(model_grant(rq_valid, last_g)));
        rq_valid[1] = 1'b0;
        @(negedge clk);
        chk("abort_issue", o_oram_input_ready, 1);
        @(negedge clk);
        rst = 1'b1;
        #1;
        chk("abort_req_ready", o_req_ready, 0);
        chk("abort_rsp_valid", o_rsp_valid, 0);
        chk("abort_rdata", o_rsp_rdata, 0);
        chk("abort_oram_pins", {o_oram_block, o_oram_rw, o_oram_input_ready, o_rsp_err}, 0);
        chk("abort_wvalue", o_oram_wvalue, 0);
        set_req(0, 1'b1, 12, rnd64());
        set_req(3, 1'b0, 12, rnd64());
        @(negedge clk);
        rst = 1'b0;
        last_g = NREQ - 1;
        access(2, 0);
        access(3, 0);

        // ORAM never answers
`ifdef ORAM_TIMEOUT_EN
        set_req(2, 1'b0, 3, rnd64());
        for (n = 0; n < 20 && o_req_ready == '0; n++) @(negedge clk);
        chk("to_grant", o_req_ready, onehot(2));
        rq_valid[2] = 1'b0;
        @(negedge clk);
        chk("to_issue", o_oram_input_ready, 1);
        for (n = 1; n < TIMEOUT; n++) begin
            @(negedge clk);
            chk("to_quiet", {o_rsp_valid, o_oram_input_ready}, 0);
        end
        @(negedge clk);
        chk("to_rsp_valid", o_rsp_valid, onehot(2));
        chk("to_rsp_err", o_rsp_err, 1);
        chk("to_rsp_rdata", o_rsp_rdata, 0);
        last_g = 2;
        @(negedge clk);
        chk("to_err_hold", o_rsp_err, 1);
`else
        set_req(2, 1'b0, 3, rnd64());
        access(1000, 0);
`endif
        set_req(1, 1'b0, 3, rnd64());
        access(1, 0);

        cnt = 0;
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            if (o_rsp_valid != '0 || o_req_ready != '0) cnt++;
        end
        chk("final_idle", cnt, 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
